// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that grants one of N requesters a single-cycle load of a
// shared W-bit enabled register, then returns a 4-phase req/ack handshake.
module reg_load_arbiter #(
  parameter int W = 5,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic           reg_en,
  output logic [W-1:0]   reg_d,
  output logic [N-1:0]   ack,
  output logic [2:0]     owner,
  output logic           busy,
  output logic [7:0]     load_count
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_e;

  state_e         state_q, state_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [2:0]     owner_q, owner_d;
  logic           reg_en_q, reg_en_d;
  logic [W-1:0]   reg_d_q, reg_d_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           busy_q, busy_d;
  logic [7:0]     load_count_q, load_count_d;

  logic           pick_valid;
  logic [2:0]     pick_idx;
  logic [3:0]     cand;

  // Search upward from ptr with wrap at N; the first set request wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      if (!pick_valid && req[cand[2:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    reg_en_d     = reg_en_q;
    reg_d_d      = reg_d_q;
    ack_d        = ack_q;
    busy_d       = busy_q;
    load_count_d = load_count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_idx;
          reg_d_d  = data[int'(pick_idx) * W +: W];
          reg_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        reg_en_d     = 1'b0;
        ack_d        = N'(1) << owner_q;
        load_count_d = load_count_q + 8'd1;
        state_d      = ACK;
      end
      ACK: begin
        // The winner drops to lowest priority once it releases.
        if (!req[owner_q]) begin
          ack_d   = '0;
          ptr_d   = (owner_q == 3'(N - 1)) ? 3'd0 : owner_q + 3'd1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      reg_en_q     <= 1'b0;
      reg_d_q      <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      reg_en_q     <= reg_en_d;
      reg_d_q      <= reg_d_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      load_count_q <= load_count_d;
    end
  end

  assign reg_en     = reg_en_q;
  assign reg_d      = reg_d_q;
  assign ack        = ack_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed scenarios plus random requesters checked
// against a transaction-timeline model of grants, loads and releases.
module tb_reg_load_arbiter;
  localparam int W = 5;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic           reg_en;
  logic [W-1:0]   reg_d;
  logic [N-1:0]   ack;
  logic [2:0]     owner;
  logic           busy;
  logic [7:0]     load_count;
  logic [W-1:0]   shared_q;

  int n_checks = 0;
  int n_fail   = 0;

  reg_load_arbiter #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .reg_en(reg_en),
    .reg_d(reg_d), .ack(ack), .owner(owner), .busy(busy), .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared d_ff_en instance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shared_q <= '0;
    else if (reg_en) shared_q <= reg_d;
  end

  // Model: one open transaction at a time, described by its grant edge.
  int           edge_no;
  bit           m_active;
  int           m_owner, m_grant_edge, m_ptr, m_count;
  logic [W-1:0] m_regd;

  wire [21:0] dut_vec = {reg_en, reg_d, ack, owner, busy, load_count};

  function automatic int rr_pick(int from, logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic logic [21:0] exp_vec();
    logic         e_en;
    logic [N-1:0] e_ack;
    e_en  = m_active && (edge_no == m_grant_edge);
    e_ack = (m_active && edge_no > m_grant_edge) ? (N'(1) << m_owner) : '0;
    return {e_en, m_regd, e_ack, 3'(m_owner), m_active, 8'(m_count)};
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_owner = 0; m_ptr = 0; m_count = 0; m_regd = '0;
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge;
  // returns at the following falling edge where outputs are sampled.
  task automatic tick();
    logic [N-1:0]   r;
    logic [N*W-1:0] d;
    r = req;
    d = data;
    @(posedge clk);
    edge_no++;
    if (!m_active) begin
      if (r != '0) begin
        m_owner      = rr_pick(m_ptr, r);
        m_active     = 1'b1;
        m_grant_edge = edge_no;
        m_regd       = d[m_owner * W +: W];
      end
    end else if (edge_no == m_grant_edge + 1) begin
      m_count = (m_count + 1) % 256;
    end else if (!r[m_owner]) begin
      m_active = 1'b0;
      m_ptr    = (m_owner + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Requesters in the mask hold ack for one cycle, release, then re-raise.
  int held [N];
  task automatic agent_rr(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) req[i] = 1'b0;
      else if (ack[i]) begin
        if (held[i] >= 1) req[i] = 1'b0;
        else held[i]++;
      end else begin
        held[i] = 0;
        req[i]  = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    req  = 4'b1111;
    data = {5'd3, 5'd2, 5'd1, 5'b10110};
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", dut_vec);
    end
    rst = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (reg_en !== 1'b1 || owner !== 3'd0 || reg_d !== 5'b10110) begin
      n_fail++;
      $display("FAIL reset_first_grant: en=%b owner=%0d d=%b expected en=1 owner=0 d=10110",
               reg_en, owner, reg_d);
    end
    tick();
    n_checks++;
    if (reg_en !== 1'b0 || ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_en_pulse: en=%b ack=%b expected en=0 ack=0001", reg_en, ack);
    end
    req = '0;
    tick();
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset();
    data = {5'd7, 5'b11001, 5'd9, 5'd4};
    req  = 4'b0100;
    tick();
    n_checks++;
    if (owner !== 3'd2 || reg_en !== 1'b1 || reg_d !== 5'b11001 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_grant: owner=%0d en=%b d=%b ack=%b expected 2 1 11001 0000",
               owner, reg_en, reg_d, ack);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0100 || reg_en !== 1'b0 || shared_q !== 5'b11001) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b en=%b q=%b expected 0100 0 11001", ack, reg_en, shared_q);
    end
    req = '0;
    tick();
    n_checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || load_count !== 8'd1) begin
      n_fail++;
      $display("FAIL single_release: ack=%b busy=%b count=%0d expected 0000 0 1",
               ack, busy, load_count);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int gedges[$];
    do_reset();
    data = {5'd31, 5'd17, 5'd8, 5'd1};
    req  = 4'b1111;
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      agent_rr(4'b1111);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      if (reg_en) begin
        grants.push_back(int'(owner));
        gedges.push_back(edge_no);
      end
    end
    n_checks++;
    if (grants.size() != 5) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d expected 5", grants.size());
    end else begin
      for (int g = 0; g < 5; g++) begin
        n_checks++;
        if (grants[g] != g % N) begin
          n_fail++;
          $display("FAIL rr_order%0d: got %0d expected %0d", g, grants[g], g % N);
        end
        if (g > 0) begin
          n_checks++;
          if (gedges[g] - gedges[g-1] != 4) begin
            n_fail++;
            $display("FAIL rr_spacing%0d: got %0d expected 4", g, gedges[g] - gedges[g-1]);
          end
        end
      end
    end
    tick();
    n_checks++;
    if (load_count !== 8'd5) begin
      n_fail++;
      $display("FAIL rr_load_count: got %0d expected 5", load_count);
    end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_wrap_skip();
    int  grants[$];
    bit  saw_ack2;
    do_reset();
    data = {5'd3, 5'd2, 5'd1, 5'd0};
    req  = 4'b0100;
    tick(); tick();
    req = '0;
    tick();
    saw_ack2 = 1'b0;
    req = 4'b1011;
    for (int c = 0; c < 40 && grants.size() < 3; c++) begin
      agent_rr(4'b1011);
      tick();
      if (ack[2]) saw_ack2 = 1'b1;
      if (reg_en) grants.push_back(int'(owner));
    end
    n_checks++;
    if (grants.size() != 3 || grants[0] != 3 || grants[1] != 0 || grants[2] != 1) begin
      n_fail++;
      $display("FAIL wrap_order: got %p expected '{3,0,1}", grants);
    end
    n_checks++;
    if (saw_ack2) begin
      n_fail++;
      $display("FAIL wrap_skip: requester 2 acked=1 expected 0");
    end
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_early_drop();
    do_reset();
    data = {5'd0, 5'd0, 5'd21, 5'd12};
    req  = 4'b0010;
    tick();
    req = '0;
    tick();
    n_checks++;
    if (ack !== 4'b0010 || load_count !== 8'd1) begin
      n_fail++;
      $display("FAIL early_ack: ack=%b count=%0d expected 0010 1", ack, load_count);
    end
    tick();
    n_checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || load_count !== 8'd1) begin
      n_fail++;
      $display("FAIL early_release: ack=%b busy=%b count=%0d expected 0000 0 1",
               ack, busy, load_count);
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (reg_en !== 1'b1 || owner !== 3'd0 || reg_d !== 5'd12) begin
      n_fail++;
      $display("FAIL early_next: en=%b owner=%0d d=%0d expected 1 0 12", reg_en, owner, reg_d);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    data = {5'd4, 5'd3, 5'd2, 5'd1};
    req  = 4'b0010;
    tick(); tick();
    req = '0;
    tick();
    req = 4'b0100;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (ack !== '0 || reg_en !== 1'b0 || busy !== 1'b0 || load_count !== 8'd0 || owner !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_async: ack=%b en=%b busy=%b count=%0d owner=%0d expected all 0",
               ack, reg_en, busy, load_count, owner);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    req = 4'b1111;
    tick();
    n_checks++;
    if (owner !== 3'd0 || reg_en !== 1'b1 || reg_d !== 5'd1) begin
      n_fail++;
      $display("FAIL midreset_priority: owner=%0d en=%b d=%0d expected 0 1 1", owner, reg_en, reg_d);
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic prev_en;
    do_reset();
    prev_en = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          end else if (m_active && m_owner == i && edge_no == m_grant_edge &&
                       $urandom_range(7, 0) == 0) begin
            req[i] = 1'b0;
          end
          if (m_active && m_owner == i && edge_no >= m_grant_edge)
            data[i*W +: W] = W'($urandom);
        end else if (!ack[i] && $urandom_range(2, 0) == 0) begin
          req[i]         = 1'b1;
          data[i*W +: W] = W'($urandom);
        end
      end
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      n_checks++;
      if (!$onehot0(ack) || (prev_en && reg_en)) begin
        n_fail++;
        $display("FAIL rand_invariant%0d: ack=%b en_prev=%b en=%b", c, ack, prev_en, reg_en);
      end
      prev_en = reg_en;
    end
  endtask

  initial begin
    edge_no = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_early_drop();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin arbiter that shares one W-bit enabled D flip-flop register (d_ff_en) among N requesters. It grants one requester at a time, drives the register's enable and data inputs for exactly one cycle, and returns a 4-phase req/ack handshake to the winner. It sits between the requesting datapath stages and the shared d_ff_en instance, whose clk and rst come from the same sources.

## Interface
- W, default 5: data width; must match the shared d_ff_en W.
- N, default 4: number of requesters; legal range 2..8.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. When low, all state and outputs are cleared immediately.
- req  input  N  request lines; bit i belongs to requester i.
- data  input  N*W  packed request data; requester i occupies bits [i*W+W-1 : i*W].
- reg_en  output  1  enable to the shared d_ff_en.
- reg_d  output  W  D input to the shared d_ff_en.
- ack  output  N  one-hot acknowledge to the granted requester.
- owner  output  3  index of the current or last granted requester.
- busy  output  1  high whenever the FSM is not in IDLE.
- load_count  output  8  number of completed loads; wraps modulo 256.

## Operation
- All outputs are registered.
- Reset values: state IDLE, reg_en 0, reg_d 0, ack 0, owner 0, busy 0, load_count 0, round-robin pointer ptr 0.

FSM states:
- IDLE
  - If no req bit is set, stay in IDLE.
  - Otherwise select the first set req bit, searching from ptr upward with wrap at N. Call it i.
  - Register owner<=i, reg_d<=data slice i, reg_en<=1, and go to LOAD.
- LOAD (always exactly one cycle)
  - Register reg_en<=0, ack[i]<=1, load_count<=load_count+1, and go to ACK.
  - reg_d holds its value; it changes only on the next grant.
- ACK
  - Hold ack[i]=1 while req[i]=1.
  - When req[i] is sampled 0, register ack<=0, ptr<=(i+1) mod N, and go to IDLE.

Handshake rules:
- The requester holds req and data stable until it sees ack.
- It then drops req.
- Data is captured once, at the grant edge. Changes to data after that edge are ignored.

Boundary conditions:
- Simultaneous requests: strict round-robin. The winner becomes lowest priority for the next arbitration.
- Pointer wrap-around: with ptr=N-1 and req=all ones, requester N-1 wins and ptr then becomes 0.
- req[i] dropped during LOAD: the load still completes. ack[i] is asserted for exactly one cycle (ACK samples req[i]=0 on its first edge), then the FSM returns to IDLE.
- req of non-owners during LOAD or ACK: ignored until IDLE.
- A requester that re-raises req immediately after its own release is re-arbitrated normally. It waits behind any other pending requester.
- ack is always one-hot or zero. reg_en is never high for more than one consecutive cycle.
- load_count wraps from 255 to 0 with no flag.
- Reset mid-operation: on any edge of rst low, all outputs go to reset values immediately, including ack and reg_en. There is no partial-load completion.

## Timing
- Edge k: IDLE samples req. reg_en=1 and reg_d are valid from k through k+1.
- Edge k+1: the shared register captures reg_d (Q valid after k+1). In the same edge, ack[i] rises and load_count increments.
- Edge m ≥ k+2: ACK samples req[i]=0, ack falls, state returns to IDLE.
- Edge m+1: earliest next grant.
- Minimum grant-to-grant period: 3 cycles.
- Minimum req-to-ack latency: 2 edges.
- busy rises at edge k and falls at edge m.

## Test plan
- Reset: hold rst=0 for 3 cycles with req=4'b1111 → all outputs 0. Release rst → grant to requester 0 at the first edge; reg_en pulses 1 cycle; reg_d=data[4:0].
- Single request: req=4'b0100, data slice 2=5'b11001 → owner=2, reg_en one cycle with reg_d=5'b11001, ack=4'b0100 one edge later, Q=5'b11001. Drop req → ack=0, busy=0, load_count=1.
- Round-robin: hold req=4'b1111, releasing each ack after 1 cycle → grant order 0,1,2,3,0. Grants are 4 cycles apart; load_count=5.
- Wrap and skip: ptr=3 with req=4'b1011 → requester 3 wins, then 0, then 1. Requester 2 is never acked.
- Early drop: req[1] falls during LOAD → ack[1] high for exactly 1 cycle, load_count increments, next request served normally.
- Mid-operation reset: assert rst=0 during ACK → ack, reg_en, busy and load_count are 0 immediately. After release, ptr=0 and requester 0 has priority.
